// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares one NSTAGE-deep pipelined fmul between two requesters.
//   clk, rstn          clock; synchronous reset, active-high despite the name
//   req{0,1}_*         operation request (valid/ready, x1, x2)
//   resp{0,1}_*        first-word-fall-through result stream (valid/ready, y, ovf)
//   fm_x1/fm_x2        registered operands to the fmul
//   fm_y/fm_ovf        fmul result, valid NSTAGE cycles after the operands
//   idle               nothing in flight and both response FIFOs empty

// Per-requester lane: credit counter plus response FIFO.
//   i_valid/o_elig     request valid in, eligibility for arbitration out
//   i_gnt              this lane was granted (credit +1)
//   i_cap/i_y/i_ovf    fmul result owned by this lane, written at the edge
//   i_ready/o_valid/o_y/o_ovf  response handshake (credit -1 on pop)
module fmul_arbiter_lane #(
  parameter int RDEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid,
  input  logic        i_gnt,
  input  logic        i_cap,
  input  logic [31:0] i_y,
  input  logic        i_ovf,
  input  logic        i_ready,
  output logic        o_elig,
  output logic        o_valid,
  output logic [31:0] o_y,
  output logic        o_ovf
);
  localparam int AW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW = $clog2(RDEPTH + 1);

  logic [32:0]   r_mem [RDEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, r_credit;
  logic          w_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(RDEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credit covers ops in flight plus buffered results, so a full credit
  // count means the FIFO can absorb everything already issued.
  assign o_elig  = i_valid && (r_credit < CW'(RDEPTH));
  assign o_valid = (r_cnt != '0);
  assign w_pop   = i_ready && o_valid;
  assign {o_ovf, o_y} = o_valid ? r_mem[r_rp] : 33'd0;

  always_ff @(posedge clk) begin
    if (i_cap) r_mem[r_wp] <= {i_ovf, i_y};
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_credit <= '0;
    end else begin
      if (i_cap) r_wp <= nxt(r_wp);
      if (w_pop) r_rp <= nxt(r_rp);
      case ({i_cap, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
      case ({i_gnt, w_pop})
        2'b10:   r_credit <= r_credit + CW'(1);
        2'b01:   r_credit <= r_credit - CW'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rstn)
    i_cap |-> (r_cnt != CW'(RDEPTH)) || w_pop);
endmodule

module fmul_arbiter #(
  parameter int NSTAGE = 3,
  parameter int RDEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_y,
  output logic        resp0_ovf,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_y,
  output logic        resp1_ovf,
  output logic [31:0] fm_x1,
  output logic [31:0] fm_x2,
  input  logic [31:0] fm_y,
  input  logic        fm_ovf,
  output logic        idle
);
  logic [1:0]        w_vld, w_rrdy, w_elig, w_gnt, w_cap, w_rvld, w_rovf;
  logic [1:0][31:0]  w_x1, w_x2, w_ry;
  logic [31:0]       r_fm_x1, r_fm_x2;
  // Stage 0 lines up with the registered operands, stage NSTAGE with fm_y.
  logic [NSTAGE:0]   r_vld_pipe, r_id_pipe;
  logic              r_prio;  // 1: requester 1 wins a tie

  assign w_vld  = {req1_valid, req0_valid};
  assign w_rrdy = {resp1_ready, resp0_ready};
  assign w_x1   = {req1_x1, req0_x1};
  assign w_x2   = {req1_x2, req0_x2};

  assign w_gnt[0] = w_elig[0] && (!w_elig[1] || !r_prio);
  assign w_gnt[1] = w_elig[1] && (!w_elig[0] ||  r_prio);

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_lane
      assign w_cap[g] = r_vld_pipe[NSTAGE] && (r_id_pipe[NSTAGE] == 1'(g));
      fmul_arbiter_lane #(.RDEPTH(RDEPTH)) u_lane (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (w_vld[g]),
        .i_gnt   (w_gnt[g]),
        .i_cap   (w_cap[g]),
        .i_y     (fm_y),
        .i_ovf   (fm_ovf),
        .i_ready (w_rrdy[g]),
        .o_elig  (w_elig[g]),
        .o_valid (w_rvld[g]),
        .o_y     (w_ry[g]),
        .o_ovf   (w_rovf[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_fm_x1    <= '0;
      r_fm_x2    <= '0;
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
      r_prio     <= 1'b0;
    end else begin
      r_fm_x1    <= w_gnt[1] ? w_x1[1] : (w_gnt[0] ? w_x1[0] : '0);
      r_fm_x2    <= w_gnt[1] ? w_x2[1] : (w_gnt[0] ? w_x2[0] : '0);
      r_vld_pipe <= {r_vld_pipe[NSTAGE-1:0], |w_gnt};
      r_id_pipe  <= {r_id_pipe[NSTAGE-1:0], w_gnt[1]};
      if (|w_gnt) r_prio <= w_gnt[0];
    end
  end

  assign req0_ready  = w_gnt[0];
  assign req1_ready  = w_gnt[1];
  assign resp0_valid = w_rvld[0];
  assign resp1_valid = w_rvld[1];
  assign resp0_y     = w_ry[0];
  assign resp1_y     = w_ry[1];
  assign resp0_ovf   = w_rovf[0];
  assign resp1_ovf   = w_rovf[1];
  assign fm_x1       = r_fm_x1;
  assign fm_x2       = r_fm_x2;
  assign idle        = !(|r_vld_pipe) && !(|w_rvld);
endmodule

// File: tb/tb_fmul_arbiter.sv
module tb_fmul_arbiter;
  localparam int NSTAGE = 3;
  localparam int RDEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
  logic        resp0_valid, resp0_ready, resp0_ovf;
  logic        resp1_valid, resp1_ready, resp1_ovf;
  logic [31:0] resp0_y, resp1_y;
  logic [31:0] fm_x1, fm_x2, fm_y;
  logic        fm_ovf, idle;

  always #5 clk = ~clk;

  fmul_arbiter #(.NSTAGE(NSTAGE), .RDEPTH(RDEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y), .resp0_ovf(resp0_ovf),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y), .resp1_ovf(resp1_ovf),
    .fm_x1(fm_x1), .fm_x2(fm_x2), .fm_y(fm_y), .fm_ovf(fm_ovf), .idle(idle)
  );

  // Single-precision multiply of normal operands; returns {ovf, y}.
  // Operands used here carry at most 12 significant bits, so truncation is exact.
  function automatic logic [32:0] fref(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    if (p[47]) begin m = p[46:24]; e = int'(a[30:23]) + int'(b[30:23]) - 126; end
    else       begin m = p[45:23]; e = int'(a[30:23]) + int'(b[30:23]) - 127; end
    if (e >= 255) return {1'b1, a[31] ^ b[31], 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, a[31] ^ b[31], 31'd0};
    return {1'b0, a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rop();
    logic [7:0]  e;
    logic [10:0] f;
    f = 11'($urandom);
    e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 254)) : 8'($urandom_range(100, 154));
    return {1'($urandom), e, f, 12'd0};
  endfunction

  // Behavioural fmul: NSTAGE cycles from operands to result.
  logic [32:0] fm_pipe [NSTAGE];
  always @(posedge clk) begin
    fm_pipe[0] <= fref(fm_x1, fm_x2);
    for (int j = 1; j < NSTAGE; j++) fm_pipe[j] <= fm_pipe[j-1];
  end
  assign {fm_ovf, fm_y} = fm_pipe[NSTAGE-1];

  int checks = 0, errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time); end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time); end
  endtask

  // Scoreboard: one queue of expected results per requester. Queue length
  // equals that requester's credit, so it also drives the grant model.
  logic [32:0] q0[$], q1[$];
  logic        mon_en = 1'b0, m_prio = 1'b0, acc0 = 1'b0, acc1 = 1'b0;
  int          n_acc = 0;

  initial forever begin
    logic e0, e1;
    logic [32:0] r;
    @(negedge clk);
    if (mon_en) begin
      if (rstn) begin
        q0.delete(); q1.delete(); m_prio = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
      end else begin
        e0 = req0_valid && (q0.size() < RDEPTH);
        e1 = req1_valid && (q1.size() < RDEPTH);
        chk1("gnt0", req0_ready, e0 && (!e1 || !m_prio));
        chk1("gnt1", req1_ready, e1 && (!e0 ||  m_prio));
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (resp0_valid && resp0_ready) begin
          if (q0.size() == 0) chk1("resp0_unexpected", 1'b1, 1'b0);
          else begin r = q0.pop_front(); chk32("resp0_y", resp0_y, r[31:0]); chk1("resp0_ovf", resp0_ovf, r[32]); end
        end
        if (resp1_valid && resp1_ready) begin
          if (q1.size() == 0) chk1("resp1_unexpected", 1'b1, 1'b0);
          else begin r = q1.pop_front(); chk32("resp1_y", resp1_y, r[31:0]); chk1("resp1_ovf", resp1_ovf, r[32]); end
        end
        if (acc0) begin q0.push_back(fref(req0_x1, req0_x2)); m_prio = 1'b1; n_acc++; end
        if (acc1) begin q1.push_back(fref(req1_x1, req1_x2)); m_prio = 1'b0; n_acc++; end
        chk1("credit_bound", (q0.size() <= RDEPTH) && (q1.size() <= RDEPTH), 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    tick(); rstn = 1'b1; tick(); rstn = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!idle && n < 200) begin @(negedge clk); n++; end
    chk1(nm, idle, 1'b1);
    chk32({nm, "_q0"}, q0.size(), 0);
    chk32({nm, "_q1"}, q1.size(), 0);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] x1, x2, y;
    logic        ovf;
  } vec_t;
  vec_t vt [5];

  // One isolated op with exact latency and passthrough checks.
  task automatic run_vec(input vec_t v);
    tick();
    if (v.id) begin req1_valid = 1'b1; req1_x1 = v.x1; req1_x2 = v.x2; end
    else      begin req0_valid = 1'b1; req0_x1 = v.x1; req0_x2 = v.x2; end
    @(negedge clk);
    chk1("v_ready", v.id ? req1_ready : req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk32("v_fm_x1", fm_x1, v.x1);
    chk32("v_fm_x2", fm_x2, v.x2);
    for (int j = 1; j <= NSTAGE; j++) begin
      @(posedge clk); @(negedge clk);
      chk1("v_early", v.id ? resp1_valid : resp0_valid, 1'b0);
      if (j == 1) chk32("v_fm_x1_clr", fm_x1, 32'd0);
    end
    @(posedge clk); @(negedge clk);
    chk1("v_valid", v.id ? resp1_valid : resp0_valid, 1'b1);
    chk1("v_other", v.id ? resp0_valid : resp1_valid, 1'b0);
    chk32("v_y", v.id ? resp1_y : resp0_y, v.y);
    chk1("v_ovf", v.id ? resp1_ovf : resp0_ovf, v.ovf);
    @(posedge clk); @(negedge clk);
    chk1("v_idle", idle, 1'b1);
  endtask

  initial begin
    int n, cyc;
    void'($urandom(32'd20240611));
    vt[0] = '{id: 1'b0, x1: 32'h3FC00000, x2: 32'h40000000, y: 32'h40400000, ovf: 1'b0};
    vt[1] = '{id: 1'b1, x1: 32'h7F000000, x2: 32'h7F000000, y: 32'h7F800000, ovf: 1'b1};
    vt[2] = '{id: 1'b1, x1: 32'hC0000000, x2: 32'h40400000, y: 32'hC0C00000, ovf: 1'b0};
    vt[3] = '{id: 1'b0, x1: 32'h3F800000, x2: 32'h3F800000, y: 32'h3F800000, ovf: 1'b0};
    vt[4] = '{id: 1'b0, x1: 32'hFF000000, x2: 32'h7F000000, y: 32'hFF800000, ovf: 1'b1};

    rstn = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x1 = '0; req0_x2 = '0; req1_x1 = '0; req1_x2 = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk32("rst_fm_x1", fm_x1, 32'd0);
    chk32("rst_fm_x2", fm_x2, 32'd0);
    chk1("rst_resp0_valid", resp0_valid, 1'b0);
    chk1("rst_resp1_valid", resp1_valid, 1'b0);
    chk32("rst_resp0_y", resp0_y, 32'd0);
    chk32("rst_resp1_y", resp1_y, 32'd0);
    chk1("rst_ovf", resp0_ovf | resp1_ovf, 1'b0);
    chk1("rst_idle", idle, 1'b1);
    tick();
    rstn = 1'b0;
    mon_en = 1'b1;

    // Directed single ops
    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Contention: strict alternation starting with requester 0
    reset_pulse();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x1 = rop(); req0_x2 = rop(); req1_x1 = rop(); req1_x2 = rop();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("alt0", req0_ready, (i % 2) == 0);
      chk1("alt1", req1_ready, (i % 2) == 1);
      tick();
      if (i % 2 == 0) begin req0_x1 = rop(); req0_x2 = rop(); end
      else            begin req1_x1 = rop(); req1_x2 = rop(); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("cont_drain");

    // Backpressure: RDEPTH accepts, then one more per dequeue
    reset_pulse();
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_x1 = rop(); req0_x2 = rop();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready) n++;
      tick();
      req0_x1 = rop(); req0_x2 = rop();
    end
    chk32("bp_accepts", n, RDEPTH);
    @(negedge clk);
    chk1("bp_stalled", req0_ready, 1'b0);
    chk1("bp_head", resp0_valid, 1'b1);
    tick();
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req0_ready) n++;
      tick();
      req0_x1 = rop(); req0_x2 = rop();
    end
    chk32("bp_one_more", n, 1);
    req0_valid = 1'b0; resp0_ready = 1'b1;
    wait_idle("bp_drain");

    // Reset with operations in flight
    reset_pulse();
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_x1 = rop(); req0_x2 = rop();
      tick();
    end
    req0_valid = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("mrst_resp0", resp0_valid, 1'b0);
      chk1("mrst_resp1", resp1_valid, 1'b0);
      chk1("mrst_idle", idle, 1'b1);
    end
    run_vec(vt[0]);

    // Random regression
    reset_pulse();
    n_acc = 0; cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 3) != 0); req0_x1 = rop(); req0_x2 = rop();
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 3) != 0); req1_x1 = rop(); req1_x2 = rop();
      end
      resp0_ready = ($urandom_range(0, 2) != 0);
      resp1_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    chk1("rnd_ops_done", n_acc >= 1000, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    wait_idle("rnd_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
